// File: rtl/shift_sequencer.sv
// Multicycle sequencer for one R-type shift: decodes funct, loads the operand,
// then issues shift commands of at most MAX_STEP positions until the amount is consumed.
module shift_sequencer #(
    parameter int MAX_STEP = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] funct,
    input  logic [4:0] shamt,
    input  logic [4:0] rs_amt,
    output logic [2:0] shift_cmd,
    output logic [4:0] shift_n,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    localparam logic [4:0] STEP = 5'(MAX_STEP);

    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_LOAD = 3'b001;
    localparam logic [2:0] CMD_SLL  = 3'b010;
    localparam logic [2:0] CMD_SRL  = 3'b011;
    localparam logic [2:0] CMD_SRA  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [4:0] r_rem;
    logic       r_ill;

    logic [2:0] w_dec_op;
    logic [4:0] w_dec_amt;
    logic       w_dec_ill;
    logic [4:0] w_step;

    always_comb begin
        w_dec_op  = CMD_NOP;
        w_dec_amt = 5'd0;
        w_dec_ill = 1'b0;
        case (funct)
            6'b000000: begin w_dec_op = CMD_SLL; w_dec_amt = shamt;  end
            6'b000010: begin w_dec_op = CMD_SRL; w_dec_amt = shamt;  end
            6'b000011: begin w_dec_op = CMD_SRA; w_dec_amt = shamt;  end
            6'b000100: begin w_dec_op = CMD_SLL; w_dec_amt = rs_amt; end
            6'b000110: begin w_dec_op = CMD_SRL; w_dec_amt = rs_amt; end
            6'b000111: begin w_dec_op = CMD_SRA; w_dec_amt = rs_amt; end
            default:   w_dec_ill = 1'b1;
        endcase
    end

    // The final step is a partial one, so the remainder can never underflow.
    assign w_step = (r_rem > STEP) ? STEP : r_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_op    <= CMD_NOP;
            r_rem   <= 5'd0;
            r_ill   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= w_dec_op;
                        r_rem <= w_dec_ill ? 5'd0 : w_dec_amt;
                        r_ill <= w_dec_ill;
                    end
                end
                S_SHIFT: r_rem <= r_rem - w_step;
                S_DONE:  r_ill <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        shift_cmd = CMD_NOP;
        shift_n   = 5'd0;
        busy      = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = w_dec_ill ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                shift_cmd = CMD_LOAD;
                busy      = 1'b1;
                w_next    = (r_rem == 5'd0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                shift_cmd = r_op;
                shift_n   = w_step;
                busy      = 1'b1;
                if (r_rem <= STEP) w_next = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                illegal = r_ill;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: two instances (MAX_STEP=1 and 8) share stimulus,
// each cycle's outputs are compared against hand-computed vectors.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [5:0] funct = 6'd0;
    logic [4:0] shamt = 5'd0;
    logic [4:0] rs_amt = 5'd0;

    logic [2:0] a_cmd, b_cmd;
    logic [4:0] a_n, b_n;
    logic       a_busy, b_busy, a_done, b_done, a_ill, b_ill;

    int n_tests = 0;
    int n_fail  = 0;
    int sum_n;

    shift_sequencer #(.MAX_STEP(1)) u_a (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .shamt(shamt),
        .rs_amt(rs_amt), .shift_cmd(a_cmd), .shift_n(a_n), .busy(a_busy),
        .done(a_done), .illegal(a_ill)
    );

    shift_sequencer #(.MAX_STEP(8)) u_b (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .shamt(shamt),
        .rs_amt(rs_amt), .shift_cmd(b_cmd), .shift_n(b_n), .busy(b_busy),
        .done(b_done), .illegal(b_ill)
    );

    always #5 clk = ~clk;

    task automatic chk_a(input string tag, input logic [2:0] cmd, input logic [4:0] n,
                         input logic bsy, input logic dn, input logic il);
        n_tests++;
        assert ({a_cmd, a_n, a_busy, a_done, a_ill} === {cmd, n, bsy, dn, il})
        else begin
            n_fail++;
            $error("FAIL %s: cmd/n/busy/done/ill got %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                   tag, a_cmd, a_n, a_busy, a_done, a_ill, cmd, n, bsy, dn, il);
        end
    endtask

    task automatic chk_b(input string tag, input logic [2:0] cmd, input logic [4:0] n,
                         input logic bsy, input logic dn, input logic il);
        n_tests++;
        assert ({b_cmd, b_n, b_busy, b_done, b_ill} === {cmd, n, bsy, dn, il})
        else begin
            n_fail++;
            $error("FAIL %s: cmd/n/busy/done/ill got %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                   tag, b_cmd, b_n, b_busy, b_done, b_ill, cmd, n, bsy, dn, il);
        end
    endtask

    // Drive a one-cycle start; returns at the negedge of cycle 1.
    task automatic issue(input logic [5:0] f, input logic [4:0] sa, input logic [4:0] rs);
        funct  = f;
        shamt  = sa;
        rs_amt = rs;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        funct  = 6'b111111;
        shamt  = 5'd17;
        rs_amt = 5'd9;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk_a("reset_a", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_b("reset_b", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle(2);
        chk_a("idle_a", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);

        // sll by 4, one position per command
        issue(6'b000000, 5'd4, 5'd0);
        chk_a("sll4_load", 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk_a($sformatf("sll4_shift_c%0d", c), 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk_a("sll4_done", 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_a("sll4_idle", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // srav by rs_amt=31 with MAX_STEP=8; shamt must be ignored
        issue(6'b000111, 5'd3, 5'd31);
        chk_b("srav_load", 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        sum_n = 0;
        @(negedge clk); sum_n += b_n; chk_b("srav_s1", 3'b100, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk); sum_n += b_n; chk_b("srav_s2", 3'b100, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk); sum_n += b_n; chk_b("srav_s3", 3'b100, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk); sum_n += b_n; chk_b("srav_s4", 3'b100, 5'd7, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_b("srav_done", 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        assert (sum_n === 31)
        else begin
            n_fail++;
            $error("FAIL srav_sum: got %0d expected 31", sum_n);
        end
        // the MAX_STEP=1 instance needs 33 cycles for the same shift
        idle(30);
        chk_a("srav_a_idle", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);

        // sra by zero: load then done, no shift command
        issue(6'b000011, 5'd0, 5'd12);
        chk_a("sra0_load", 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("sra0_done", 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_a("sra0_idle", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // illegal funct (add)
        issue(6'b100000, 5'd4, 5'd4);
        chk_a("ill_done_a", 3'b000, 5'd0, 1'b1, 1'b1, 1'b1);
        chk_b("ill_done_b", 3'b000, 5'd0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk_a("ill_idle_a", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // srl by 5 with a stray start in cycle 3 (B is in DONE then)
        issue(6'b000010, 5'd5, 5'd0);
        chk_a("srl5_load", 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("srl5_s1", 3'b011, 5'd1, 1'b1, 1'b0, 1'b0);
        chk_b("srl5_b_shift", 3'b011, 5'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("srl5_s2", 3'b011, 5'd1, 1'b1, 1'b0, 1'b0);
        chk_b("srl5_b_done", 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
        funct = 6'b000000; shamt = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_a("srl5_s3", 3'b011, 5'd1, 1'b1, 1'b0, 1'b0);
        chk_b("srl5_b_start_in_done_ignored", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("srl5_s4", 3'b011, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("srl5_s5", 3'b011, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("srl5_done", 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_a("srl5_idle1", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("srl5_idle2", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        chk_b("srl5_b_idle", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // asynchronous reset in the middle of SHIFT
        issue(6'b000000, 5'd4, 5'd0);
        @(negedge clk);
        chk_a("rst_pre_shift", 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_a("rst_async_a", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        chk_a("rst_no_done", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);

        // normal operation after reset: sllv by rs_amt=2
        issue(6'b000100, 5'd30, 5'd2);
        chk_a("post_rst_load", 3'b001, 5'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("post_rst_s1", 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
        chk_b("post_rst_b_s1", 3'b010, 5'd2, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("post_rst_s2", 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_a("post_rst_done", 3'b000, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_a("post_rst_idle", 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
